score_sequencer: RTL and testbench

//  Owns the game score and decides what the two-digit score display shows.

---
 rtl/score_sequencer.sv | 153 +++++++++++++++
 tb/tb_score_sequencer.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/score_sequencer.sv
// Score counter and two-digit display sequencer: counts points, saturates, and on game over
// alternates score/high score with a blink on a new record (the latter only with SCORE_HIGH_EN).
module score_sequencer #(
    parameter int unsigned MAX_SCORE    = 99,
    parameter int unsigned ALT_CYCLES   = 25_000_000,
    parameter int unsigned BLINK_CYCLES = 12_500_000
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Inc,
    input  logic       i_Clear,
    input  logic       i_Game_Over,
    output logic [6:0] o_Score,
    output logic       o_Blank,
    output logic [6:0] o_High_Score,
    output logic       o_New_High,
    output logic [1:0] o_State
);

    typedef enum logic [1:0] {
        StPlay      = 2'b00,
        StOverScore = 2'b01,
        StOverHigh  = 2'b10
    } state_t;

    localparam logic [6:0] MaxScore = 7'(MAX_SCORE);

    state_t     r_state, w_state_d;
    logic [6:0] r_score, w_score_d;
    logic [6:0] r_disp, w_disp_d;
    logic [6:0] w_score_inc;

`ifdef SCORE_HIGH_EN
    localparam int unsigned AltW   = (ALT_CYCLES > 1) ? $clog2(ALT_CYCLES) : 1;
    localparam int unsigned BlinkW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [AltW-1:0]   AltLast   = AltW'(ALT_CYCLES - 1);
    localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_CYCLES - 1);

    logic [6:0]        r_high, w_high_d;
    logic              r_new_high, w_new_high_d;
    logic              r_blank, w_blank_d;
    logic [AltW-1:0]   r_alt, w_alt_d;
    logic [BlinkW-1:0] r_blink, w_blink_d;
`endif

    assign w_score_inc = (r_score >= MaxScore) ? r_score : r_score + 7'd1;

    always_comb begin
        w_state_d = r_state;
        w_score_d = r_score;
`ifdef SCORE_HIGH_EN
        w_high_d     = r_high;
        w_new_high_d = r_new_high;
        w_blank_d    = r_blank;
        w_alt_d      = r_alt;
        w_blink_d    = r_blink;
`endif
        if (i_Clear) begin
            w_state_d = StPlay;
            w_score_d = '0;
`ifdef SCORE_HIGH_EN
            w_new_high_d = 1'b0;
            w_blank_d    = 1'b0;
            w_alt_d      = '0;
            w_blink_d    = '0;
`endif
        end else begin
            case (r_state)
                StPlay: begin
                    if (i_Inc) w_score_d = w_score_inc;
                    if (i_Game_Over) begin
                        w_state_d = StOverScore;
`ifdef SCORE_HIGH_EN
                        w_alt_d   = '0;
                        w_blink_d = '0;
                        w_blank_d = 1'b0;
                        // Compare against the score including a same-cycle point
                        if (w_score_d > r_high) begin
                            w_high_d     = w_score_d;
                            w_new_high_d = 1'b1;
                        end
`endif
                    end
                end
`ifdef SCORE_HIGH_EN
                StOverScore, StOverHigh: begin
                    if (r_alt == AltLast) begin
                        w_alt_d   = '0;
                        w_state_d = (r_state == StOverScore) ? StOverHigh : StOverScore;
                    end else begin
                        w_alt_d = r_alt + 1'b1;
                    end
                    if (r_new_high) begin
                        if (r_blink == BlinkLast) begin
                            w_blink_d = '0;
                            w_blank_d = ~r_blank;
                        end else begin
                            w_blink_d = r_blink + 1'b1;
                        end
                    end
                end
`else
                StOverScore: ;
`endif
                default: w_state_d = StPlay;
            endcase
        end
`ifdef SCORE_HIGH_EN
        w_disp_d = (w_state_d == StOverHigh) ? w_high_d : w_score_d;
`else
        w_disp_d = w_score_d;
`endif
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_state <= StPlay;
            r_score <= '0;
            r_disp  <= '0;
`ifdef SCORE_HIGH_EN
            r_high     <= '0;
            r_new_high <= 1'b0;
            r_blank    <= 1'b0;
            r_alt      <= '0;
            r_blink    <= '0;
`endif
        end else begin
            r_state <= w_state_d;
            r_score <= w_score_d;
            r_disp  <= w_disp_d;
`ifdef SCORE_HIGH_EN
            r_high     <= w_high_d;
            r_new_high <= w_new_high_d;
            r_blank    <= w_blank_d;
            r_alt      <= w_alt_d;
            r_blink    <= w_blink_d;
`endif
        end
    end

    assign o_Score = r_disp;
    assign o_State = r_state;
`ifdef SCORE_HIGH_EN
    assign o_High_Score = r_high;
    assign o_New_High   = r_new_high;
    assign o_Blank      = r_blank;
`else
    assign o_High_Score = '0;
    assign o_New_High   = 1'b0;
    assign o_Blank      = 1'b0;
`endif

endmodule

// File: tb/tb_score_sequencer.sv
// Directed bench for score_sequencer with ALT_CYCLES=8, BLINK_CYCLES=2; expectations follow
// whichever SCORE_HIGH_EN setting the build uses.
module tb_score_sequencer;

`ifdef SCORE_HIGH_EN
    localparam bit HighEn = 1'b1;
`else
    localparam bit HighEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       inc = 1'b0, clr = 1'b0, go = 1'b0;
    logic [6:0] score, high;
    logic       blank, new_high;
    logic [1:0] state;

    int errors = 0;
    int checks = 0;

    score_sequencer #(
        .MAX_SCORE   (99),
        .ALT_CYCLES  (8),
        .BLINK_CYCLES(2)
    ) dut (
        .i_Clk       (clk),
        .i_Reset     (rst),
        .i_Inc       (inc),
        .i_Clear     (clr),
        .i_Game_Over (go),
        .o_Score     (score),
        .o_Blank     (blank),
        .o_High_Score(high),
        .o_New_High  (new_high),
        .o_State     (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       inc, clr, go;
        logic [6:0] score;
        logic [1:0] state;
    } vec_t;

    task automatic step(input logic i, input logic c, input logic g);
        inc = i; clr = c; go = g;
        @(posedge clk);
        #1;
        inc = 1'b0; clr = 1'b0; go = 1'b0;
    endtask

    task automatic check(input string name, input logic [6:0] e_score, input logic e_blank,
                         input logic [6:0] e_high, input logic e_nh, input logic [1:0] e_state);
        checks++;
        if ({score, blank, high, new_high, state} !== {e_score, e_blank, e_high, e_nh, e_state})
        begin
            errors++;
            $display("FAIL %s: got score=%0d blank=%b high=%0d new_high=%b state=%b, want score=%0d blank=%b high=%0d new_high=%b state=%b",
                     name, score, blank, high, new_high, state,
                     e_score, e_blank, e_high, e_nh, e_state);
        end
    endtask

    initial begin
        vec_t       tbl[9];
        logic [6:0] hm;
        logic [1:0] st;

        tbl[0] = '{1, 0, 0, 7'd1, 2'b00};
        tbl[1] = '{1, 0, 0, 7'd2, 2'b00};
        tbl[2] = '{1, 0, 0, 7'd3, 2'b00};
        tbl[3] = '{1, 0, 0, 7'd4, 2'b00};
        tbl[4] = '{1, 0, 0, 7'd5, 2'b00};
        tbl[5] = '{1, 1, 1, 7'd0, 2'b00};  // clear wins over inc and game over
        tbl[6] = '{1, 0, 0, 7'd1, 2'b00};
        tbl[7] = '{0, 0, 0, 7'd1, 2'b00};
        tbl[8] = '{0, 1, 0, 7'd0, 2'b00};

        step(0, 0, 0);
        step(0, 0, 0);
        check("reset", 7'd0, 1'b0, 7'd0, 1'b0, 2'b00);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            step(tbl[i].inc, tbl[i].clr, tbl[i].go);
            check($sformatf("table[%0d]", i), tbl[i].score, 1'b0, 7'd0, 1'b0, tbl[i].state);
        end

        for (int i = 1; i <= 120; i++) begin
            step(1, 0, 0);
            check($sformatf("saturate[%0d]", i), (i > 99) ? 7'd99 : 7'(i), 1'b0, 7'd0, 1'b0,
                  2'b00);
        end
        step(0, 1, 0);
        check("clear_after_sat", 7'd0, 1'b0, 7'd0, 1'b0, 2'b00);

        // Score 7, then point and game over together
        for (int i = 0; i < 7; i++) step(1, 0, 0);
        check("score7", 7'd7, 1'b0, 7'd0, 1'b0, 2'b00);
        hm = HighEn ? 7'd8 : 7'd0;
        step(1, 0, 1);
        check("gameover_new_high", 7'd8, 1'b0, hm, HighEn, 2'b01);
        for (int k = 1; k <= 20; k++) begin
            step(k == 3, 0, k == 3);
            st = (HighEn && ((k / 8) % 2 == 1)) ? 2'b10 : 2'b01;
            check($sformatf("over_blink[%0d]", k), 7'd8, HighEn && ((k / 2) % 2 == 1), hm,
                  HighEn, st);
        end

        // Lower score: no new record, no blink, display alternates 3/8
        step(0, 1, 0);
        check("clear_keeps_high", 7'd0, 1'b0, hm, 1'b0, 2'b00);
        for (int i = 0; i < 3; i++) step(1, 0, 0);
        check("score3", 7'd3, 1'b0, hm, 1'b0, 2'b00);
        step(0, 0, 1);
        check("gameover_low", 7'd3, 1'b0, hm, 1'b0, 2'b01);
        for (int k = 1; k <= 12; k++) begin
            step(0, 0, 0);
            st = (HighEn && ((k / 8) % 2 == 1)) ? 2'b10 : 2'b01;
            check($sformatf("over_alt[%0d]", k), (st == 2'b10) ? 7'd8 : 7'd3, 1'b0, hm, 1'b0,
                  st);
        end

        step(1, 1, 0);
        check("clear_in_over", 7'd0, 1'b0, hm, 1'b0, 2'b00);

        // New record, then reset while blanked
        for (int i = 0; i < 9; i++) step(1, 0, 0);
        step(0, 0, 1);
        hm = HighEn ? 7'd9 : 7'd0;
        check("gameover_9", 7'd9, 1'b0, hm, HighEn, 2'b01);
        for (int k = 1; k <= 3; k++) begin
            step(0, 0, 0);
            check($sformatf("blink9[%0d]", k), 7'd9, HighEn && ((k / 2) % 2 == 1), hm, HighEn,
                  2'b01);
        end
        rst = 1'b1;
        step(0, 0, 0);
        check("reset_mid_blink", 7'd0, 1'b0, 7'd0, 1'b0, 2'b00);
        rst = 1'b0;
        step(1, 0, 0);
        check("after_reset_inc", 7'd1, 1'b0, 7'd0, 1'b0, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
